// File: rtl/offset_metric_acc.sv
// ============================================================================
// Module      : offset_metric_acc
// Description : Timing-offset scan engine. For each of NUM_OFF candidate
//               offsets it accumulates ACC_LEN squared errors (samp-ref)^2
//               through a 3-stage pipeline and emits one metric per offset.
//               Optional macro OFFSET_METRIC_SAT_EN makes the accumulator
//               saturate at 36'hFFFFFFFFF instead of wrapping modulo 2^36.
//               The expected-sample port is named ref_val because "ref" is a
//               reserved SystemVerilog keyword.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module offset_metric_acc #(
    parameter int NUM_OFF = 64,
    parameter int ACC_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               samp_valid,
    input  logic signed [15:0] samp,
    input  logic signed [15:0] ref_val,
    output logic               min_clr,
    output logic               metric_en,
    output logic        [12:0] idx,
    output logic        [35:0] metric,
    output logic               busy,
    output logic               done
);

    localparam int         c_OFF_W     = 13;
    localparam int         c_CNT_W     = 7;
    localparam logic [c_OFF_W-1:0] c_LAST_OFF  = c_OFF_W'(NUM_OFF - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_SAMP = c_CNT_W'(ACC_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_drain_cnt;

    logic [c_CNT_W-1:0]   r_samp_cnt;
    logic [c_OFF_W-1:0]   r_off_cnt;

    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_last_samp;
    logic                 w_drain_end;

    logic                 r_s1_vld;
    logic                 r_s1_last;
    logic [c_OFF_W-1:0]   r_s1_off;
    logic signed [16:0]   r_s1_diff;

    logic                 r_s2_vld;
    logic                 r_s2_last;
    logic [c_OFF_W-1:0]   r_s2_off;
    logic [31:0]          r_s2_sq;

    logic [15:0]          w_mag;
    logic [31:0]          w_sq;
    logic [35:0]          r_acc;
    logic [35:0]          w_acc_nxt;

    logic                 r_done_p1;
    logic                 r_done_p2;

    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign w_accept    = (r_state == ST_ACC) && samp_valid;
    assign w_last_samp = (r_samp_cnt == c_LAST_SAMP);
    assign w_drain_end = (r_state == ST_DRAIN) && r_drain_cnt;
    assign busy        = (r_state != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_ACC;
            ST_ACC:   if (w_accept && w_last_samp && (r_off_cnt == c_LAST_OFF))
                          w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Two-cycle drain timer; zero whenever outside DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_cnt <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= ~r_drain_cnt;
        end else begin
            r_drain_cnt <= 1'b0;
        end
    end

    // Sample and offset counters; sample counter wraps at ACC_LEN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp_cnt <= '0;
            r_off_cnt  <= '0;
        end else if (w_start_ok) begin
            r_samp_cnt <= '0;
            r_off_cnt  <= '0;
        end else if (w_accept) begin
            if (w_last_samp) begin
                r_samp_cnt <= '0;
                r_off_cnt  <= r_off_cnt + 1'b1;
            end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
            end
        end
    end

    // Minimum-search clear pulse in the cycle following an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            min_clr <= 1'b0;
        end else begin
            min_clr <= w_start_ok;
        end
    end

    // Stage 1: difference, with last tag and offset travelling alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_off  <= '0;
            r_s1_diff <= '0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_last <= w_accept && w_last_samp;
            r_s1_off  <= r_off_cnt;
            r_s1_diff <= {samp[15], samp} - {ref_val[15], ref_val};
        end
    end

    // |diff| never exceeds 65535, so the square is formed from a 16-bit magnitude
    assign w_mag = r_s1_diff[16] ? 16'(-r_s1_diff) : r_s1_diff[15:0];
    assign w_sq  = {16'd0, w_mag} * {16'd0, w_mag};

    // Stage 2: squared error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_off  <= '0;
            r_s2_sq   <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            r_s2_off  <= r_s1_off;
            r_s2_sq   <= w_sq;
        end
    end

`ifdef OFFSET_METRIC_SAT_EN
    logic [36:0] w_sum;
    assign w_sum     = {1'b0, r_acc} + {5'd0, r_s2_sq};
    assign w_acc_nxt = w_sum[36] ? {36{1'b1}} : w_sum[35:0];
`else
    assign w_acc_nxt = r_acc + {4'd0, r_s2_sq};
`endif

    // Stage 3: accumulate; a tagged square closes the offset and restarts acc
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            metric    <= '0;
            idx       <= '0;
            metric_en <= 1'b0;
        end else begin
            metric_en <= 1'b0;
            if (r_s2_vld) begin
                if (r_s2_last) begin
                    metric    <= w_acc_nxt;
                    idx       <= r_s2_off;
                    metric_en <= 1'b1;
                    r_acc     <= '0;
                end else begin
                    r_acc     <= w_acc_nxt;
                end
            end
        end
    end

    // Done follows the end of DRAIN by two cycles, i.e. two cycles after the
    // final metric_en pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_p1 <= 1'b0;
            r_done_p2 <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_done_p1 <= w_drain_end;
            r_done_p2 <= r_done_p1;
            done      <= r_done_p2;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_offset_metric_acc.sv
// ============================================================================
// Module      : tb_offset_metric_acc
// Description : Scoreboard bench for offset_metric_acc (4 offsets x 2 samples)
//               plus a 1 offset x 64 sample instance for the accumulator limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_offset_metric_acc;

    localparam int NUM_OFF = 4;
    localparam int ACC_LEN = 2;
    localparam int W_LEN   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, samp_valid;
    logic [15:0] samp, ref_val;
    logic        min_clr, metric_en, busy, done;
    logic [12:0] idx;
    logic [35:0] metric;

    logic        w_start, w_valid;
    logic [15:0] w_samp, w_ref;
    logic        w_min_clr, w_metric_en, w_busy, w_done;
    logic [12:0] w_idx;
    logic [35:0] w_metric;

    always #5 clk = ~clk;

    offset_metric_acc #(.NUM_OFF(NUM_OFF), .ACC_LEN(ACC_LEN)) u_dut (
        .clk(clk), .rst(rst), .start(start), .samp_valid(samp_valid),
        .samp(samp), .ref_val(ref_val), .min_clr(min_clr),
        .metric_en(metric_en), .idx(idx), .metric(metric),
        .busy(busy), .done(done));

    offset_metric_acc #(.NUM_OFF(1), .ACC_LEN(W_LEN)) u_wide (
        .clk(clk), .rst(rst), .start(w_start), .samp_valid(w_valid),
        .samp(w_samp), .ref_val(w_ref), .min_clr(w_min_clr),
        .metric_en(w_metric_en), .idx(w_idx), .metric(w_metric),
        .busy(w_busy), .done(w_done));

    typedef struct {
        logic [12:0] idx;
        logic [35:0] metric;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_me_cyc = 0;
    int          n_done = 0;
    int          n_me = 0;
    int          exp_done = 0;
    bit          mon_on = 0;
    logic [12:0] last_idx = '0;

    bit          m_act = 0;
    int          m_off, m_cnt;
    logic [35:0] m_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [35:0] m_add(input logic [35:0] a, input logic [35:0] b);
        logic [36:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef OFFSET_METRIC_SAT_EN
        if (s[36]) return {36{1'b1}};
`endif
        return s[35:0];
    endfunction

    function automatic logic [35:0] sq_err(input logic [15:0] s, input logic [15:0] r);
        longint d;
        d = longint'($signed(s)) - longint'($signed(r));
        return 36'(d * d);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected metrics, checks idx hold and done spacing
    always @(negedge clk) begin
        if (mon_on) begin
            if (metric_en) begin
                exp_t e;
                n_me++;
                chk("metric_en_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("idx", idx, e.idx);
                    chk("metric", metric, e.metric);
                end
                last_idx    = idx;
                last_me_cyc = cyc;
            end else begin
                chk("idx_hold", idx, last_idx);
            end
            if (done) begin
                n_done++;
                chk("done_gap", cyc - last_me_cyc, 2);
            end
        end
    end

    // One cycle of stimulus; the model follows every accepted sample
    task automatic send(input logic [15:0] s, input logic [15:0] r, input logic v,
                        input logic st);
        logic [35:0] sq;
        samp = s; ref_val = r; samp_valid = v; start = st;
        @(posedge clk);
        if (v && m_act) begin
            sq    = sq_err(s, r);
            m_cnt = m_cnt + 1;
            if (m_cnt == ACC_LEN) begin
                sb.push_back('{idx: 13'(m_off), metric: m_add(m_acc, sq)});
                m_acc = '0;
                m_cnt = 0;
                m_off = m_off + 1;
                if (m_off == NUM_OFF) begin
                    m_act    = 0;
                    exp_done = exp_done + 1;
                end
            end else begin
                m_acc = m_add(m_acc, sq);
            end
        end
        @(negedge clk);
        samp_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        m_act = 1; m_off = 0; m_cnt = 0; m_acc = '0;
        @(negedge clk);
        start = 1'b0;
        chk("min_clr", min_clr, 1);
        chk("busy_scan", busy, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(16'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic end_scan(input string tag);
        idle(8);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_done_cnt"}, n_done, exp_done);
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] x;
        logic [35:0] w_exp;
        bit          seen;

        rst = 1'b1; start = 0; samp_valid = 0; samp = '0; ref_val = '0;
        w_start = 0; w_valid = 0; w_samp = '0; w_ref = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_metric", metric, 0);
        chk("rst_idx", idx, 0);
        chk("rst_metric_en", metric_en, 0);
        chk("rst_min_clr", min_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        mon_on = 1;

        // samp == ref: zero metric for every offset
        do_start();
        for (int i = 0; i < NUM_OFF * ACC_LEN; i++) begin
            x = 16'($urandom);
            send(x, x, 1'b1, 1'b0);
        end
        end_scan("zero");

        // constant 100 / -100 with a start pulse while busy
        do_start();
        for (int i = 0; i < NUM_OFF * ACC_LEN; i++)
            send(16'd100, 16'hFF9C, 1'b1, (i == 3 || i == 7));
        send(16'd0, 16'd0, 1'b0, 1'b1);
        end_scan("const");

        // 1,0,0,1 valid pattern then random data with random gaps
        do_start();
        send(16'd300, 16'd20, 1'b1, 1'b0);
        send(16'd999, 16'd1, 1'b0, 1'b0);
        send(16'd999, 16'd1, 1'b0, 1'b0);
        send(16'hFF00, 16'd77, 1'b1, 1'b0);
        for (int k = 0; k < 200 && m_act; k++)
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        chk("gaps_complete", m_act, 0);
        end_scan("gaps");

        // extreme operands
        do_start();
        for (int i = 0; i < NUM_OFF * ACC_LEN; i++)
            send(16'h8000, 16'h7FFF, 1'b1, 1'b0);
        end_scan("extreme");

        // abort once idx 1 has been emitted
        n_me = 0;
        do_start();
        for (int k = 0; k < 50 && n_me < 2; k++)
            send(16'($urandom), 16'($urandom), 1'b1, 1'b0);
        chk("abort_reached_idx1", n_me >= 2, 1);
        mon_on = 0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        m_act = 0;
        last_idx = '0;
        rst = 1'b0;
        mon_on = 1;
        idle(10);
        chk("abort_busy", busy, 0);
        chk("abort_done_cnt", n_done, exp_done);

        // new scan after abort restarts at idx 0
        do_start();
        for (int i = 0; i < NUM_OFF * ACC_LEN; i++)
            send(16'($urandom), 16'($urandom), 1'b1, 1'b0);
        end_scan("restart");

        // 64 extreme samples on one offset: accumulator limit
        w_exp = '0;
        for (int i = 0; i < W_LEN; i++) w_exp = m_add(w_exp, 36'd4294836225);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        w_samp = 16'h8000; w_ref = 16'h7FFF; w_valid = 1'b1;
        repeat (W_LEN) @(negedge clk);
        w_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (w_metric_en) begin
                seen = 1;
                chk("wide_metric", w_metric, w_exp);
                chk("wide_idx", w_idx, 0);
            end else begin
                @(negedge clk);
            end
        end
        chk("wide_metric_en_seen", seen, 1);

        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/offset_metric_acc.md
OFFSET_METRIC_ACC -- requirements
Module: offset_metric_acc

Interface
REQ-001 Parameter NUM_OFF, default 64, number of candidate timing offsets scanned (range 1..8192).
REQ-002 Parameter ACC_LEN, default 16, samples accumulated per offset (range 1..64).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a scan; honoured only in IDLE.
REQ-006 samp_valid  input  1  samp and ref are valid this cycle.
REQ-007 samp  input  16  signed received sample.
REQ-008 ref  input  16  signed expected sample.
REQ-009 min_clr  output  1  one-cycle pulse that clears the downstream minimum search.
REQ-010 metric_en  output  1  one-cycle pulse; metric and idx are valid.
REQ-011 idx  output  13  offset index belonging to metric.
REQ-012 metric  output  36  unsigned accumulated squared error.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the scan completes.

Function
REQ-015 FSM states SHALL be IDLE, ACC and DRAIN.
REQ-016 IDLE->ACC on start; min_clr SHALL be high in the cycle after start is sampled; the offset counter and sample counter SHALL clear to 0.
REQ-017 In ACC, each cycle with samp_valid=1 SHALL be one accepted sample; samp_valid in IDLE or DRAIN SHALL be ignored.
REQ-018 Pipeline: stage1 registers diff=samp-ref (17-bit signed); stage2 registers diff*diff (32-bit unsigned); stage3 accumulates.
REQ-019 The sample counter SHALL tag the ACC_LEN-th accepted sample of each offset as last; the tag travels with the data through stages 1-2.
REQ-020 On a tagged square, stage3 SHALL load metric with acc+square, idx with the offset, and pulse metric_en; acc SHALL restart at 0 with no bubble.
REQ-021 Latency: for a last sample accepted on edge E, metric, idx and metric_en SHALL update on edge E+2.
REQ-022 Valid gaps are allowed at any point; partial accumulations SHALL persist across gaps.
REQ-023 After the last sample of offset NUM_OFF-1, the FSM SHALL go ACC->DRAIN; DRAIN SHALL last 2 cycles, then done SHALL pulse and the FSM SHALL return to IDLE.
REQ-024 start in ACC or DRAIN SHALL be ignored.
REQ-025 idx SHALL hold its last value between metric_en pulses; metric_en SHALL never be asserted in IDLE except during the final drain pulse.
REQ-026 Exactly NUM_OFF metric_en pulses SHALL occur per scan, with idx ascending 0..NUM_OFF-1.

Reset
REQ-027 When rst=1 on an edge: state=IDLE, all counters, pipeline registers and acc cleared; metric=0, idx=0; metric_en, min_clr, done and busy low.
REQ-028 rst mid-scan SHALL abort the scan with no further metric_en or done pulses; rst SHALL take priority over start.

Configuration
REQ-029 With macro OFFSET_METRIC_SAT_EN defined, the accumulator SHALL saturate at 36'hFFFFFFFFF.
REQ-030 Without OFFSET_METRIC_SAT_EN, the accumulator SHALL wrap modulo 2^36.

Verification
REQ-031 NUM_OFF=4, ACC_LEN=2, samp=ref every cycle -> four metric_en pulses with metric=0 and idx 0,1,2,3; done pulses 2 cycles after the last metric_en.
REQ-032 samp=100, ref=-100, ACC_LEN=16 -> metric=640000 for each idx.
REQ-033 samp=-32768, ref=32767, ACC_LEN=64: with SAT_EN -> metric=36'hFFFFFFFFF; without SAT_EN -> metric=(64*4294836225) mod 2^36.
REQ-034 samp_valid toggled 1,0,0,1 with ACC_LEN=2 -> metric_en on edge E+2 of the second valid sample; metric equals the sum of both squares.
REQ-035 rst asserted after idx=1 is emitted in a 4-offset scan -> no further metric_en or done; busy=0; a new start gives min_clr and idx restarting at 0.
REQ-036 start pulsed while busy -> scan unaffected; exactly NUM_OFF pulses and one done.
